// File: rtl/imgproc_msg_reader_if.sv
// Avalon-MM master port through which the message reader polls the image
// processor's status/message registers and issues buffer flushes.
interface imgproc_msg_reader_if;
  // Handshake: fixed-latency Avalon-MM with no waitrequest. A read is one
  // cycle of m_chipselect & m_read; m_readdata is valid exactly one cycle
  // later. A write is one cycle of m_chipselect & m_write with m_address and
  // m_writedata valid in that same cycle.
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_read;
  logic        m_write;
  logic [31:0] m_writedata;
  logic [31:0] m_readdata;

  modport master (
    output m_address, m_chipselect, m_read, m_write, m_writedata,
    input  m_readdata
  );

  modport slave (
    input  m_address, m_chipselect, m_read, m_write, m_writedata,
    output m_readdata
  );
endinterface

// File: rtl/imgproc_msg_reader.sv
// Polls the image processor for colour-bound messages, latches red/green/pink
// x bounds, derives detection and centre, and services message-buffer flushes.
module imgproc_msg_reader #(
  parameter int POLL_INTERVAL = 1024,
  parameter int MAX_BATCH     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        flush_req,
  imgproc_msg_reader_if.master        mm,
  output logic [10:0]                 r_x_min,
  output logic [10:0]                 r_x_max,
  output logic [10:0]                 g_x_min,
  output logic [10:0]                 g_x_max,
  output logic [10:0]                 p_x_min,
  output logic [10:0]                 p_x_max,
  output logic                        r_det,
  output logic                        g_det,
  output logic                        p_det,
  output logic [10:0]                 r_centre,
  output logic [10:0]                 g_centre,
  output logic [10:0]                 p_centre,
  output logic [2:0]                  upd,
  output logic [7:0]                  err_count,
  output logic                        busy,
  output logic [2:0]                  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_STAT = 3'd1,
    S_WT_STAT = 3'd2,
    S_RD_MSG  = 3'd3,
    S_WT_MSG  = 3'd4,
    S_GAP     = 3'd5,
    S_FLUSH   = 3'd6
  } state_e;

  localparam int              TW           = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0]   TIMER_RELOAD = TW'(POLL_INTERVAL - 1);
  localparam logic [7:0]      BATCH_CAP    = 8'(MAX_BATCH);
  localparam logic [10:0]     X_LIMIT      = 11'd639;
  localparam logic [10:0]     X_MIN_RST    = 11'd639;
  localparam logic [31:0]     FLUSH_CMD    = 32'h10;

  state_e              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic                was_idle_q, was_idle_d;
  logic [7:0]          remaining_q, remaining_d;
  logic                pend_q, pend_d;
  logic [7:0]          err_q, err_d;
  logic [2:0][10:0]    x_min_q, x_min_d;
  logic [2:0][10:0]    x_max_q, x_max_d;
  logic [2:0]          upd_q, upd_d;

  logic [7:0]          rd_id;
  logic [10:0]         rd_lo;
  logic [10:0]         rd_hi;
  logic                rd_bad;
  logic [7:0]          stat_cnt;
  logic [7:0]          batch_len;

  assign rd_id     = mm.m_readdata[31:24];
  assign rd_lo     = mm.m_readdata[22:12];
  assign rd_hi     = mm.m_readdata[10:0];
  assign rd_bad    = mm.m_readdata[23] | mm.m_readdata[11] | (rd_lo > X_LIMIT) | (rd_hi > X_LIMIT);
  assign stat_cnt  = mm.m_readdata[15:8];
  assign batch_len = (stat_cnt > BATCH_CAP) ? BATCH_CAP : stat_cnt;

  always_comb begin
    state_d         = state_q;
    timer_d         = timer_q;
    was_idle_d      = (state_q == S_IDLE);
    remaining_d     = remaining_q;
    pend_d          = pend_q | flush_req;
    err_d           = err_q;
    x_min_d         = x_min_q;
    x_max_d         = x_max_q;
    upd_d           = 3'b000;
    mm.m_address    = 3'd0;
    mm.m_chipselect = 1'b0;
    mm.m_read       = 1'b0;
    mm.m_write      = 1'b0;
    mm.m_writedata  = 32'h0;

    unique case (state_q)
      S_IDLE: begin
        // The first IDLE cycle only reloads the timer, so a full poll cycle
        // spans POLL_INTERVAL+3 clocks.
        if (pend_q) begin
          state_d = S_FLUSH;
          pend_d  = 1'b0;
        end else if (!was_idle_q) begin
          timer_d = TIMER_RELOAD;
        end else if (enable) begin
          if (timer_q == '0) state_d = S_RD_STAT;
          else               timer_d = timer_q - TW'(1);
        end
      end
      S_RD_STAT: begin
        mm.m_chipselect = 1'b1;
        mm.m_read       = 1'b1;
        mm.m_address    = 3'd0;
        state_d         = S_WT_STAT;
      end
      S_WT_STAT: begin
        remaining_d = batch_len;
        state_d     = (batch_len == 8'd0) ? S_IDLE : S_RD_MSG;
      end
      S_RD_MSG: begin
        mm.m_chipselect = 1'b1;
        mm.m_read       = 1'b1;
        mm.m_address    = 3'd1;
        state_d         = S_WT_MSG;
      end
      S_WT_MSG: begin
        remaining_d = remaining_q - 8'd1;
        state_d     = S_GAP;
        if (!rd_bad && (rd_id == 8'd1 || rd_id == 8'd2 || rd_id == 8'd3)) begin
          // id 1/2/3 maps to slot 0/1/2 (red/green/pink).
          x_min_d[rd_id[1:0] - 2'd1] = rd_lo;
          x_max_d[rd_id[1:0] - 2'd1] = rd_hi;
          upd_d[rd_id[1:0] - 2'd1]   = 1'b1;
        end else if (err_q != 8'hFF) begin
          err_d = err_q + 8'd1;
        end
      end
      S_GAP: begin
        state_d = (remaining_q != 8'd0) ? S_RD_MSG : S_IDLE;
      end
      S_FLUSH: begin
        mm.m_chipselect = 1'b1;
        mm.m_write      = 1'b1;
        mm.m_address    = 3'd0;
        mm.m_writedata  = FLUSH_CMD;
        state_d         = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      timer_q     <= TIMER_RELOAD;
      was_idle_q  <= 1'b1;
      remaining_q <= 8'd0;
      pend_q      <= 1'b0;
      err_q       <= 8'd0;
      x_min_q     <= {3{X_MIN_RST}};
      x_max_q     <= '0;
      upd_q       <= 3'b000;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      was_idle_q  <= was_idle_d;
      remaining_q <= remaining_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      x_min_q     <= x_min_d;
      x_max_q     <= x_max_d;
      upd_q       <= upd_d;
    end
  end

  function automatic logic [10:0] centre_of(input logic [10:0] lo, input logic [10:0] hi);
    logic [11:0] sum;
    sum = {1'b0, lo} + {1'b0, hi};
    return (lo <= hi) ? sum[11:1] : 11'd0;
  endfunction

  assign r_x_min   = x_min_q[0];
  assign r_x_max   = x_max_q[0];
  assign g_x_min   = x_min_q[1];
  assign g_x_max   = x_max_q[1];
  assign p_x_min   = x_min_q[2];
  assign p_x_max   = x_max_q[2];
  assign r_det     = (x_min_q[0] <= x_max_q[0]);
  assign g_det     = (x_min_q[1] <= x_max_q[1]);
  assign p_det     = (x_min_q[2] <= x_max_q[2]);
  assign r_centre  = centre_of(x_min_q[0], x_max_q[0]);
  assign g_centre  = centre_of(x_min_q[1], x_max_q[1]);
  assign p_centre  = centre_of(x_min_q[2], x_max_q[2]);
  assign upd       = upd_q;
  assign err_count = err_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_imgproc_msg_reader.sv
// Randomised scoreboard bench for imgproc_msg_reader: an MM slave model feeds
// status/message words while a reference model predicts every message outcome.
module tb_imgproc_msg_reader;
  localparam int P     = 16;
  localparam int MB    = 8;
  localparam int OBS_W = 113;

  logic        clk = 1'b0;
  logic        reset, enable, flush_req;
  logic [10:0] r_x_min, r_x_max, g_x_min, g_x_max, p_x_min, p_x_max;
  logic        r_det, g_det, p_det;
  logic [10:0] r_centre, g_centre, p_centre;
  logic [2:0]  upd;
  logic [7:0]  err_count;
  logic        busy;
  logic [2:0]  dbg_state;

  imgproc_msg_reader_if mm();

  imgproc_msg_reader #(.POLL_INTERVAL(P), .MAX_BATCH(MB)) dut (
    .clk(clk), .reset(reset), .enable(enable), .flush_req(flush_req), .mm(mm),
    .r_x_min(r_x_min), .r_x_max(r_x_max), .g_x_min(g_x_min), .g_x_max(g_x_max),
    .p_x_min(p_x_min), .p_x_max(p_x_max), .r_det(r_det), .g_det(g_det), .p_det(p_det),
    .r_centre(r_centre), .g_centre(g_centre), .p_centre(p_centre), .upd(upd),
    .err_count(err_count), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int                 vectors = 0;
  int                 miscompares = 0;
  logic [OBS_W-1:0]   exp_q[$];
  logic [34:0]        wr_exp_q[$];
  logic [31:0]        stat_q[$];
  logic [31:0]        msg_q[$];
  logic [31:0]        dir_q[$];
  int                 stat_t[$];
  int                 mdl_min[3];
  int                 mdl_max[3];
  int                 mdl_err;
  int                 cycle = 0, stat_reads = 0, msg_reads = 0, writes = 0;
  bit                 force_err = 0;
  logic               resp_valid = 1'b0;
  logic [31:0]        resp_next = 32'h0;
  logic [31:0]        rdata;
  logic               p1 = 1'b0, p2 = 1'b0, prev_rd = 1'b0;

  // Read data is only meaningful the cycle after a strobe; otherwise noise.
  assign mm.m_readdata = rdata;
  always @(posedge clk) rdata <= resp_valid ? resp_next : $urandom;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp_v, cycle);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic void model_reset();
    for (int i = 0; i < 3; i++) begin
      mdl_min[i] = 639;
      mdl_max[i] = 0;
    end
    mdl_err = 0;
  endfunction

  function automatic logic [OBS_W-1:0] model_obs(input logic [2:0] u);
    logic [10:0] mn[3], mx[3], ce[3];
    logic [2:0]  dt;
    for (int i = 0; i < 3; i++) begin
      mn[i] = 11'(mdl_min[i]);
      mx[i] = 11'(mdl_max[i]);
      dt[i] = (mdl_min[i] <= mdl_max[i]);
      ce[i] = dt[i] ? 11'((mdl_min[i] + mdl_max[i]) / 2) : 11'd0;
    end
    return {u, 8'(mdl_err), mn[0], mx[0], mn[1], mx[1], mn[2], mx[2], dt, ce[0], ce[1], ce[2]};
  endfunction

  function automatic logic [OBS_W-1:0] dut_obs();
    return {upd, err_count, r_x_min, r_x_max, g_x_min, g_x_max, p_x_min, p_x_max,
            {p_det, g_det, r_det}, r_centre, g_centre, p_centre};
  endfunction

  function automatic logic [2:0] model_msg(input logic [31:0] w);
    int id, lo, hi, b23, b11;
    id  = int'(w >> 24);
    b23 = int'((w >> 23) % 2);
    lo  = int'((w >> 12) % 2048);
    b11 = int'((w >> 11) % 2);
    hi  = int'(w % 2048);
    if (b23 != 0 || b11 != 0 || lo > 639 || hi > 639 || id < 1 || id > 3) begin
      if (mdl_err < 255) mdl_err++;
      return 3'b000;
    end
    mdl_min[id-1] = lo;
    mdl_max[id-1] = hi;
    return 3'(1 << (id - 1));
  endfunction

  function automatic logic [31:0] gen_msg();
    int kind, id, lo, hi;
    logic [31:0] w;
    kind = force_err ? int'($urandom_range(7, 9)) : int'($urandom_range(0, 9));
    id   = int'($urandom_range(1, 3));
    lo   = int'($urandom_range(0, 639));
    hi   = int'($urandom_range(0, 639));
    if (kind == 6) begin
      lo = int'($urandom_range(321, 639));
      hi = int'($urandom_range(0, 320));
    end
    if (kind == 7) id = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(4, 255));
    if (kind == 9) begin
      if ($urandom_range(0, 1) == 0) lo = int'($urandom_range(640, 2047));
      else                          hi = int'($urandom_range(640, 2047));
    end
    w = {8'(id), 1'b0, 11'(lo), 1'b0, 11'(hi)};
    if (kind == 8) begin
      if ($urandom_range(0, 1) == 0) w[23] = 1'b1;
      else                           w[11] = 1'b1;
    end
    return w;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_poll(input int count);
    logic [31:0] s, w;
    logic [2:0]  u;
    int          n;
    s       = $urandom;
    s[15:8] = 8'(count);
    stat_q.push_back(s);
    n = (count < MB) ? count : MB;
    for (int i = 0; i < n; i++) begin
      w = (dir_q.size() != 0) ? dir_q.pop_front() : gen_msg();
      msg_q.push_back(w);
      u = model_msg(w);
      exp_q.push_back(model_obs(u));
    end
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (stat_q.size() == 0 && msg_q.size() == 0 && exp_q.size() == 0 &&
          wr_exp_q.size() == 0 && !busy) begin
        done = 1;
        break;
      end
    end
    check(name, 128'(done), 128'd1);
  endtask

  task automatic wait_msg_read(input string name);
    int base = msg_reads;
    bit got  = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (msg_reads != base) begin
        got = 1;
        break;
      end
    end
    check(name, 128'(got), 128'd1);
  endtask

  // ---------------- monitor / slave responder ----------------
  task automatic monitor();
    forever begin
      @(negedge clk);
      cycle++;
      resp_valid = 1'b0;
      if (mm.m_read) begin
        check("read_cs", 128'(mm.m_chipselect), 128'd1);
        check("read_spacing", 128'(prev_rd), 128'd0);
        check("read_addr", 128'(mm.m_address <= 3'd1), 128'd1);
        if (mm.m_address == 3'd0) begin
          stat_reads++;
          stat_t.push_back(cycle);
          resp_next  = (stat_q.size() != 0) ? stat_q.pop_front() : ($urandom & 32'hFFFF00FF);
          resp_valid = 1'b1;
        end else if (mm.m_address == 3'd1) begin
          msg_reads++;
          check("msg_avail", 128'(msg_q.size() != 0), 128'd1);
          resp_next  = (msg_q.size() != 0) ? msg_q.pop_front() : 32'h0;
          resp_valid = 1'b1;
        end
      end
      if (mm.m_write) begin
        writes++;
        check("write_cs", 128'(mm.m_chipselect), 128'd1);
        check("flush_order", 128'(exp_q.size()), 128'd0);
        if (wr_exp_q.size() != 0) check("flush_write", 128'({mm.m_address, mm.m_writedata}), 128'(wr_exp_q.pop_front()));
        else                      check("extra_write", 128'd1, 128'd0);
      end
      if (!busy)
        check("idle_bus", 128'({mm.m_chipselect, mm.m_read, mm.m_write, mm.m_address, mm.m_writedata}), 128'd0);
      if (p2) begin
        if (exp_q.size() != 0) check("msg_record", 128'(dut_obs()), 128'(exp_q.pop_front()));
        else                   check("extra_record", 128'd1, 128'd0);
      end else begin
        check("stray_upd", 128'(upd), 128'd0);
      end
      p2      = p1 && !reset;
      p1      = mm.m_read && (mm.m_address == 3'd1) && !reset;
      prev_rd = mm.m_read;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int base, sr;
    bit got;
    reset     = 1'b1;
    enable    = 1'b0;
    flush_req = 1'b0;
    model_reset();
    fork
      monitor();
    join_none
    repeat (3) tick();
    check("reset_obs", 128'(dut_obs()), 128'(model_obs(3'b000)));
    check("reset_bus", 128'({mm.m_chipselect, mm.m_read, mm.m_write, mm.m_address, mm.m_writedata}), 128'd0);
    check("reset_busy", 128'(busy), 128'd0);
    reset  = 1'b0;
    enable = 1'b1;

    // Empty polls: period between status reads.
    stat_t.delete();
    got = 0;
    for (int i = 0; i < 6 * P; i++) begin
      tick();
      if (stat_t.size() >= 3) begin
        got = 1;
        break;
      end
    end
    check("poll_seen", 128'(got), 128'd1);
    if (got) begin
      check("poll_period_a", 128'(stat_t[1] - stat_t[0]), 128'(P + 3));
      check("poll_period_b", 128'(stat_t[2] - stat_t[1]), 128'(P + 3));
    end
    check("no_msg_reads", 128'(msg_reads), 128'd0);

    // Red 100..200 then green 50..100.
    dir_q.push_back(32'h010640C8);
    dir_q.push_back(32'h02032064);
    push_poll(2);
    wait_drain("drain_rg");
    check("r_centre", 128'(r_centre), 128'd150);
    check("g_centre", 128'(g_centre), 128'd75);
    check("r_det", 128'(r_det), 128'd1);

    // Oversized count is capped at MAX_BATCH.
    base = msg_reads;
    push_poll(20);
    wait_drain("drain_cap");
    check("batch_cap", 128'(msg_reads - base), 128'(MB));

    // No-detection pink, unknown id, out-of-range x_max.
    dir_q.push_back(32'h0327F000);
    dir_q.push_back(32'h070640C8);
    dir_q.push_back(32'h010642BC);
    push_poll(3);
    wait_drain("drain_err");
    check("p_det_nodet", 128'(p_det), 128'd0);
    check("p_centre_nodet", 128'(p_centre), 128'd0);

    for (int k = 0; k < 15; k++) begin
      push_poll(int'($urandom_range(0, 12)));
      wait_drain("drain_rand");
    end

    // Flush requested mid-batch.
    base = writes;
    push_poll(4);
    wait_msg_read("flush_batch_start");
    wr_exp_q.push_back({3'd0, 32'h10});
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_drain("drain_flush");
    check("flush_count", 128'(writes - base), 128'd1);

    // Flush with polling disabled.
    enable = 1'b0;
    repeat (4) tick();
    wr_exp_q.push_back({3'd0, 32'h10});
    flush_req = 1'b1;
    tick();
    flush_req = 1'b0;
    wait_drain("drain_flush_dis");

    // Enable dropped mid-batch.
    enable = 1'b1;
    base   = msg_reads;
    push_poll(5);
    wait_msg_read("en_batch_start");
    enable = 1'b0;
    wait_drain("drain_en_low");
    check("en_low_batch", 128'(msg_reads - base), 128'd5);
    sr = stat_reads;
    repeat (3 * P) tick();
    check("poll_suppressed", 128'(stat_reads), 128'(sr));
    enable = 1'b1;

    // Reset while waiting for message data.
    dir_q.push_back(32'h010140C8);
    push_poll(3);
    wait_msg_read("rst_batch_start");
    reset = 1'b1;
    tick();
    model_reset();
    exp_q.delete();
    msg_q.delete();
    stat_q.delete();
    dir_q.delete();
    check("rst_mid_bus", 128'({mm.m_chipselect, mm.m_read, mm.m_write}), 128'd0);
    check("rst_mid_busy", 128'(busy), 128'd0);
    check("rst_mid_obs", 128'(dut_obs()), 128'(model_obs(3'b000)));
    reset = 1'b0;
    push_poll(1);
    wait_drain("drain_post_rst");

    // Error counter saturation.
    force_err = 1;
    for (int k = 0; k < 33; k++) begin
      push_poll(8);
      wait_drain("drain_sat");
    end
    check("err_saturated", 128'(err_count), 128'd255);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
